// File: rtl/handshake_arr_responder_pkg.sv
// Shared types and sizing for the handshake_arr responder: lane index, FIFO entry
// layout and the reduction flag stored alongside each buffered word.
package handshake_pkg;

  localparam int NUM_LANES = 3;
  localparam int WIDTH     = 4;
  localparam int DEPTH     = 4;

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef struct packed {
    lane_idx_t        lane;
    logic [WIDTH-1:0] data;
    logic             flag;
  } hs_entry_t;

  // Nonzero and all ones; evaluated once at push time and stored with the word.
  function automatic logic reduce_flag(input logic [WIDTH-1:0] data);
    return (|data) && (&data);
  endfunction

endpackage

// File: rtl/handshake_arr_responder_if.sv
// Bundle of the producer lanes and the single downstream ready/valid port.
// The responder uses the slave modport; whoever drives the lanes uses master.
interface handshake_arr_responder_if;
  import handshake_pkg::*;

  logic [NUM_LANES-1:0]       handshake_arr_valid;
  logic [NUM_LANES*WIDTH-1:0] handshake_arr_data;
  logic [NUM_LANES-1:0]       handshake_arr_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  lane_idx_t                  out_lane;
  logic                       out_flag;
  logic [CNT_W-1:0]           fifo_count;
  logic [NUM_LANES-1:0]       proto_err;

  modport master (
    output handshake_arr_valid, handshake_arr_data, out_ready,
    input  handshake_arr_ready, out_valid, out_data, out_lane, out_flag,
           fifo_count, proto_err
  );

  modport slave (
    input  handshake_arr_valid, handshake_arr_data, out_ready,
    output handshake_arr_ready, out_valid, out_data, out_lane, out_flag,
           fifo_count, proto_err
  );

endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin lane arbiter: grants the first requesting lane at or after the
// pointer, and moves the pointer past the grantee only when a transfer happens.
module handshake_rr_arbiter
  import handshake_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_LANES-1:0] req_i,
  input  logic                 enable_i,
  input  logic                 accept_i,
  output logic [NUM_LANES-1:0] grant_o,
  output lane_idx_t            grant_idx_o
);

  lane_idx_t ptr_q, ptr_d;
  lane_idx_t cand;
  logic      found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = lane_idx_t'((int'(ptr_q) + k) % NUM_LANES);
      if (enable_i && !found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (grant_idx_o == lane_idx_t'(NUM_LANES - 1)) ? '0
                                                          : grant_idx_o + lane_idx_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/handshake_arr_responder.sv
// Consumer end of the handshake_arr lanes: round-robin accept into a small FIFO,
// tag each word with lane and flag, and record producer protocol violations.
module handshake_arr_responder
  import handshake_pkg::*;
(
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  handshake_arr_responder_if.slave hs
);

  logic [NUM_LANES-1:0] grant;
  lane_idx_t            grantIdx;
  logic                 notFull;
  logic                 push;
  logic                 pop;
  hs_entry_t            pushEntry;

  hs_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0]     laneData [NUM_LANES];
  logic [WIDTH-1:0]     capData_q [NUM_LANES];
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] protoErr_q, protoErr_d;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      laneData[i] = hs.handshake_arr_data[i*WIDTH +: WIDTH];
    end
  end

  // No full-pass-through: a pop in the same cycle never opens a lane while full.
  assign notFull = (count_q != CNT_W'(DEPTH));

  handshake_rr_arbiter u_arbiter (
    .clk_i       (CLK),
    .rst_ni      (ASYNCRESETN),
    .req_i       (hs.handshake_arr_valid),
    .enable_i    (notFull && ASYNCRESETN),
    .accept_i    (push),
    .grant_o     (grant),
    .grant_idx_o (grantIdx)
  );

  assign hs.handshake_arr_ready = grant;
  assign push = |(grant & hs.handshake_arr_valid);
  assign pop  = (count_q != '0) && hs.out_ready;

  always_comb begin
    pushEntry      = '0;
    pushEntry.lane = grantIdx;
    pushEntry.data = laneData[grantIdx];
    pushEntry.flag = reduce_flag(laneData[grantIdx]);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= pushEntry;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // A lane left waiting at the last edge must hold valid and data until accepted.
  always_comb begin
    protoErr_d = protoErr_q;
    pending_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pending_q[i] && (!hs.handshake_arr_valid[i] || (laneData[i] != capData_q[i]))) begin
        protoErr_d[i] = 1'b1;
      end
      pending_d[i] = hs.handshake_arr_valid[i] && !grant[i];
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        capData_q[i] <= '0;
      end
      pending_q  <= '0;
      protoErr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        capData_q[i] <= laneData[i];
      end
      pending_q  <= pending_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign hs.out_valid  = (count_q != '0);
  assign hs.out_data   = mem_q[rdPtr_q].data;
  assign hs.out_lane   = mem_q[rdPtr_q].lane;
  assign hs.out_flag   = mem_q[rdPtr_q].flag;
  assign hs.fifo_count = count_q;
  assign hs.proto_err  = protoErr_q;

  always_ff @(posedge CLK) begin
    if (ASYNCRESETN) begin
      assert ($onehot0(hs.handshake_arr_ready));
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_handshake_arr_responder.sv
// Bench for handshake_arr_responder: directed scenarios plus random traffic, all
// compared against a queue-based model of arbitration, FIFO and protocol rules.
module tb_handshake_arr_responder;
  import handshake_pkg::*;

  localparam int VW = NUM_LANES + 1 + WIDTH + LANE_W + 1 + CNT_W + NUM_LANES;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;

  handshake_arr_responder_if hsIf ();

  handshake_arr_responder dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .hs          (hsIf.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int lane;
    int data;
    bit flag;
  } modelEntry_t;

  modelEntry_t          expQ[$];
  int                   rrPtr;
  bit [NUM_LANES-1:0]   expErr;
  bit [NUM_LANES-1:0]   pend;
  int                   cap [NUM_LANES];
  int                   testsRun = 0;
  int                   failCount = 0;

  function automatic int laneDataOf(input int l);
    return int'(hsIf.handshake_arr_data[l*WIDTH +: WIDTH]);
  endfunction

  function automatic logic [NUM_LANES-1:0] modelReady();
    logic [NUM_LANES-1:0] r;
    int l;
    r = '0;
    if (ASYNCRESETN && expQ.size() < DEPTH) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        l = (rrPtr + k) % NUM_LANES;
        if (hsIf.handshake_arr_valid[l]) begin
          r[l] = 1'b1;
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    expQ.delete();
    rrPtr  = 0;
    expErr = '0;
    pend   = '0;
    for (int l = 0; l < NUM_LANES; l++) cap[l] = 0;
  endtask

  task automatic modelStep();
    logic [NUM_LANES-1:0] r;
    modelEntry_t e;
    r = modelReady();
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pend[l] && (!hsIf.handshake_arr_valid[l] || laneDataOf(l) != cap[l])) expErr[l] = 1'b1;
      pend[l] = hsIf.handshake_arr_valid[l] && !r[l];
      cap[l]  = laneDataOf(l);
    end
    if (expQ.size() > 0 && hsIf.out_ready) void'(expQ.pop_front());
    for (int l = 0; l < NUM_LANES; l++) begin
      if (r[l]) begin
        e.lane = l;
        e.data = laneDataOf(l);
        e.flag = (e.data == (1 << WIDTH) - 1);
        expQ.push_back(e);
        rrPtr = (l + 1) % NUM_LANES;
      end
    end
  endtask

  function automatic logic [VW-1:0] expVec();
    logic [WIDTH+LANE_W:0] head;
    head = '0;
    if (expQ.size() > 0) head = {WIDTH'(expQ[0].data), LANE_W'(expQ[0].lane), expQ[0].flag};
    return {modelReady(), expQ.size() != 0, head, CNT_W'(expQ.size()), expErr};
  endfunction

  // Head fields are only meaningful while the model holds a word.
  function automatic logic [VW-1:0] obsVec();
    logic [WIDTH+LANE_W:0] head;
    head = '0;
    if (expQ.size() > 0) head = {hsIf.out_data, hsIf.out_lane, hsIf.out_flag};
    return {hsIf.handshake_arr_ready, hsIf.out_valid, head, hsIf.fifo_count, hsIf.proto_err};
  endfunction

  task automatic setLane(input int l, input logic v, input int d);
    hsIf.handshake_arr_valid[l]              = v;
    hsIf.handshake_arr_data[l*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic tick();
    modelStep();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyReset();
    ASYNCRESETN               = 1'b0;
    hsIf.handshake_arr_valid  = '0;
    hsIf.handshake_arr_data   = '0;
    hsIf.out_ready            = 1'b0;
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs;
    ASYNCRESETN              = 1'b0;
    hsIf.handshake_arr_valid = '1;
    hsIf.handshake_arr_data  = '1;
    hsIf.out_ready           = 1'b1;
    modelReset();
    @(negedge CLK);
    #1;
    obs = {hsIf.handshake_arr_ready, hsIf.out_valid, hsIf.out_data, hsIf.out_lane,
           hsIf.out_flag, hsIf.fifo_count, hsIf.proto_err};
    testsRun++;
    if (obs !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
    applyReset();
  endtask

  task automatic test_single();
    logic [VW-1:0] exp;
    applyReset();
    hsIf.out_ready = 1'b1;
    setLane(1, 1'b1, 'hF);
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== 3'b010) begin
      failCount++;
      $display("[TB] FAIL single_ready: got %b expected 010", hsIf.handshake_arr_ready);
    end
    tick();
    setLane(1, 1'b0, 0);
    #1;
    exp = {3'b000, 1'b1, 4'hF, 2'd1, 1'b1, 3'd1, 3'b000};
    testsRun++;
    if (obsVec() !== exp || expVec() !== exp) begin
      failCount++;
      $display("[TB] FAIL single_head: got %h expected %h", obsVec(), exp);
    end
  endtask

  task automatic test_round_robin();
    int expLane[4] = '{0, 1, 2, 0};
    int expData[4] = '{1, 2, 3, 1};
    logic [NUM_LANES-1:0] oneHot;
    applyReset();
    for (int l = 0; l < NUM_LANES; l++) setLane(l, 1'b1, l + 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      oneHot = NUM_LANES'(1 << expLane[c]);
      testsRun++;
      if (hsIf.handshake_arr_ready !== oneHot || obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL rr_grant%0d: got ready %b expected %b", c, hsIf.handshake_arr_ready, oneHot);
      end
      tick();
    end
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== '0 || hsIf.fifo_count !== CNT_W'(4)) begin
      failCount++;
      $display("[TB] FAIL rr_full: got ready %b count %0d expected 000 and 4", hsIf.handshake_arr_ready, hsIf.fifo_count);
    end
    hsIf.handshake_arr_valid = '0;
    hsIf.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      testsRun++;
      if (hsIf.out_data !== WIDTH'(expData[c]) || obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL rr_drain%0d: got data %h expected %h", c, hsIf.out_data, expData[c]);
      end
      tick();
    end
  endtask

  task automatic test_full_pop();
    applyReset();
    setLane(0, 1'b1, 6);
    for (int c = 0; c < 4; c++) tick();
    hsIf.out_ready = 1'b1;
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== '0 || hsIf.fifo_count !== CNT_W'(4) || obsVec() !== expVec()) begin
      failCount++;
      $display("[TB] FAIL full_pop_noready: got ready %b count %0d expected 000 and 4", hsIf.handshake_arr_ready, hsIf.fifo_count);
    end
    tick();
    hsIf.out_ready = 1'b0;
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== 3'b001 || hsIf.fifo_count !== CNT_W'(3)) begin
      failCount++;
      $display("[TB] FAIL full_pop_refill: got ready %b count %0d expected 001 and 3", hsIf.handshake_arr_ready, hsIf.fifo_count);
    end
    tick();
    #1;
    testsRun++;
    if (hsIf.fifo_count !== CNT_W'(4) || obsVec() !== expVec()) begin
      failCount++;
      $display("[TB] FAIL full_pop_back: got count %0d expected 4", hsIf.fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    int l;
    applyReset();
    setLane(0, 1'b1, 9);
    tick();
    setLane(0, 1'b1, 10);
    tick();
    hsIf.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      hsIf.handshake_arr_valid = '0;
      l = $urandom_range(NUM_LANES - 1);
      setLane(l, 1'b1, $urandom_range((1 << WIDTH) - 1));
      #1;
      testsRun++;
      if (hsIf.fifo_count !== CNT_W'(2) || obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL b2b%0d: got %h expected %h", c, obsVec(), expVec());
      end
      tick();
    end
    hsIf.handshake_arr_valid = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      testsRun++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL b2b_drain%0d: got %h expected %h", c, obsVec(), expVec());
      end
      tick();
    end
  endtask

  task automatic test_proto_err();
    applyReset();
    setLane(0, 1'b1, 3);
    for (int c = 0; c < 4; c++) tick();
    setLane(0, 1'b0, 0);
    setLane(2, 1'b1, 5);
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== '0) begin
      failCount++;
      $display("[TB] FAIL proto_stall: got ready %b expected 000", hsIf.handshake_arr_ready);
    end
    tick();
    setLane(2, 1'b0, 5);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      testsRun++;
      if (hsIf.proto_err !== 3'b100 || obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL proto_sticky%0d: got err %b expected 100", c, hsIf.proto_err);
      end
      tick();
    end
    hsIf.out_ready = 1'b1;
    setLane(2, 1'b1, 8);
    tick();
    tick();
    setLane(2, 1'b0, 8);
    tick();
    tick();
    #1;
    testsRun++;
    if (hsIf.out_data !== 4'h8 || hsIf.out_lane !== 2'd2 || hsIf.out_flag !== 1'b0 ||
        hsIf.proto_err !== 3'b100 || obsVec() !== expVec()) begin
      failCount++;
      $display("[TB] FAIL proto_flag: got data %h lane %0d flag %b err %b expected 8 2 0 100",
               hsIf.out_data, hsIf.out_lane, hsIf.out_flag, hsIf.proto_err);
    end
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] obs;
    applyReset();
    for (int l = 0; l < NUM_LANES; l++) setLane(l, 1'b1, l + 1);
    for (int c = 0; c < 3; c++) tick();
    #2;
    ASYNCRESETN = 1'b0;
    modelReset();
    #1;
    obs = {hsIf.handshake_arr_ready, hsIf.out_valid, hsIf.out_data, hsIf.out_lane,
           hsIf.out_flag, hsIf.fifo_count, hsIf.proto_err};
    testsRun++;
    if (obs !== '0) begin
      failCount++;
      $display("[TB] FAIL midreset_clear: got %h expected 0", obs);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    testsRun++;
    if (hsIf.handshake_arr_ready !== 3'b001 || obsVec() !== expVec()) begin
      failCount++;
      $display("[TB] FAIL midreset_grant: got ready %b expected 001", hsIf.handshake_arr_ready);
    end
    tick();
    #1;
    testsRun++;
    if (hsIf.out_lane !== 2'd0 || hsIf.out_data !== 4'h1 || obsVec() !== expVec()) begin
      failCount++;
      $display("[TB] FAIL midreset_head: got lane %0d data %h expected 0 1", hsIf.out_lane, hsIf.out_data);
    end
  endtask

  // Legal producers hold a stalled word; roughly one stall in thirty is broken on purpose.
  task automatic test_random();
    applyReset();
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pend[l]) begin
          if ($urandom_range(29) == 0) begin
            if ($urandom_range(1) == 0) setLane(l, 1'b0, 0);
            else setLane(l, 1'b1, laneDataOf(l) ^ 1);
          end
        end else begin
          setLane(l, 1'($urandom_range(1)), $urandom_range((1 << WIDTH) - 1));
        end
      end
      hsIf.out_ready = ($urandom_range(9) < 6);
      #1;
      testsRun++;
      if (obsVec() !== expVec()) begin
        failCount++;
        $display("[TB] FAIL random%0d: got %h expected %h", c, obsVec(), expVec());
      end
      tick();
    end
  endtask

  initial begin
    hsIf.handshake_arr_valid = '0;
    hsIf.handshake_arr_data  = '0;
    hsIf.out_ready           = 1'b0;
    modelReset();
    @(negedge CLK);
    test_reset();
    test_single();
    test_round_robin();
    test_full_pop();
    test_back_to_back();
    test_proto_err();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
